// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans 32 attribute slots (31 down to 0) and keeps the first four visible sprites.
// Latency: start to done is 34 cycles (32 reads, 1 drain, 1 commit); the next start is accepted in the cycle after done.
// Backpressure: none; start is a pulse honoured only when idle, and the memory is assumed to answer every read 1 cycle later.
//
// Ports: clk/reset_n (async active-low); start + line_y kick a scan; mem_addr/mem_rd issue reads and mem_entry/mem_y
// return one cycle later; busy covers the scan; done pulses on commit; h3_out..h0_out, count and overflow hold the
// committed list, with h3_out the highest priority.
module sprite_line_scheduler #(
    parameter int SPRITE_H = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [8:0]  line_y,
    output logic [4:0]  mem_addr,
    output logic        mem_rd,
    input  logic [17:0] mem_entry,
    input  logic [8:0]  mem_y,
    output logic        busy,
    output logic        done,
    output logic [22:0] h3_out,
    output logic [22:0] h2_out,
    output logic [22:0] h1_out,
    output logic [22:0] h0_out,
    output logic [2:0]  count,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

    localparam logic [9:0] H_LIM = 10'(SPRITE_H);

    state_t      state;
    logic [8:0]  line_q;
    logic        eval_vld;    // read data for eval_slot is on mem_entry/mem_y this cycle
    logic [4:0]  eval_slot;
    logic [22:0] wl [4];
    logic [2:0]  wcnt;
    logic        wovf;

    logic [22:0] wl_nxt [4];
    logic [2:0]  wcnt_nxt;
    logic        wovf_nxt;
    logic [8:0]  diff;
    logic        hit;

    // 9-bit wrap subtraction makes sprites straddling line 511/0 visible on the low lines.
    assign diff = line_q - mem_y;
    assign hit  = eval_vld && (mem_entry != '0) && ({1'b0, diff} < H_LIM);

    // Working list with the current slot folded in; the tag 31-s is simply the inverted slot number.
    always_comb begin
        for (int i = 0; i < 4; i++) wl_nxt[i] = wl[i];
        wcnt_nxt = wcnt;
        wovf_nxt = wovf;
        if (hit) begin
            if (wcnt < 3'd4) begin
                wl_nxt[wcnt[1:0]] = {~eval_slot, mem_entry};
                wcnt_nxt          = wcnt + 3'd1;
            end else begin
                wovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            line_q    <= '0;
            eval_vld  <= 1'b0;
            eval_slot <= '0;
            for (int i = 0; i < 4; i++) wl[i] <= '0;
            wcnt      <= '0;
            wovf      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            h3_out    <= '0;
            h2_out    <= '0;
            h1_out    <= '0;
            h0_out    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            eval_vld  <= mem_rd;
            eval_slot <= mem_addr;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        line_q <= line_y;
                        for (int i = 0; i < 4; i++) wl[i] <= '0;
                        wcnt     <= '0;
                        wovf     <= 1'b0;
                        mem_addr <= 5'd31;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    for (int i = 0; i < 4; i++) wl[i] <= wl_nxt[i];
                    wcnt <= wcnt_nxt;
                    wovf <= wovf_nxt;
                    if (mem_addr == 5'd0) begin
                        mem_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr - 5'd1;
                    end
                end
                DRAIN: begin
                    // Slot 0 is evaluated here; publishing from the _nxt values lets the
                    // committed list appear exactly in the cycle done is high.
                    for (int i = 0; i < 4; i++) wl[i] <= wl_nxt[i];
                    wcnt     <= wcnt_nxt;
                    wovf     <= wovf_nxt;
                    h3_out   <= wl_nxt[0];
                    h2_out   <= wl_nxt[1];
                    h1_out   <= wl_nxt[2];
                    h0_out   <= wl_nxt[3];
                    count    <= wcnt_nxt;
                    overflow <= wovf_nxt;
                    done     <= 1'b1;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: registered attribute memory model, cycle-phase reference model, random scans.
// Latency: n/a.
// Backpressure: n/a.
module tb_sprite_line_scheduler;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  line_y = '0;
    logic [4:0]  mem_addr;
    logic        mem_rd;
    logic [17:0] mem_entry = '0;
    logic [8:0]  mem_y = '0;
    logic        busy, done;
    logic [22:0] h3_out, h2_out, h1_out, h0_out;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [17:0] ent [32];
    logic [8:0]  ymem [32];

    // reference model state
    int          phase = 0;    // 0 idle, k = k-th cycle after an accepted start
    logic [22:0] exp_h [4];
    int          exp_cnt = 0;
    bit          exp_ovf = 0;
    logic [22:0] pend_h [4];
    int          pend_cnt = 0;
    bit          pend_ovf = 0;

    sprite_line_scheduler #(.SPRITE_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .line_y(line_y),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_entry(mem_entry), .mem_y(mem_y),
        .busy(busy), .done(done),
        .h3_out(h3_out), .h2_out(h2_out), .h1_out(h1_out), .h0_out(h0_out),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // attribute memory: one-cycle registered read
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_entry <= ent[mem_addr];
            mem_y     <= ymem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the visible list is computed from the whole memory at start, published 34 cycles later.
    always @(posedge clk) begin
        if (!reset_n) begin
            phase = 0;
            for (int i = 0; i < 4; i++) exp_h[i] = '0;
            exp_cnt = 0;
            exp_ovf = 0;
        end else if (phase == 0 && start) begin
            for (int i = 0; i < 4; i++) pend_h[i] = '0;
            pend_cnt = 0;
            pend_ovf = 0;
            for (int s = 31; s >= 0; s--) begin
                int d;
                d = (int'(line_y) - int'(ymem[s]) + 512) % 512;
                if (ent[s] != 0 && d < H) begin
                    if (pend_cnt < 4) begin
                        pend_h[pend_cnt] = {5'(31 - s), ent[s]};
                        pend_cnt++;
                    end else begin
                        pend_ovf = 1;
                    end
                end
            end
            phase = 1;
        end else if (phase > 0) begin
            phase++;
            if (phase == 34) begin
                for (int i = 0; i < 4; i++) exp_h[i] = pend_h[i];
                exp_cnt = pend_cnt;
                exp_ovf = pend_ovf;
            end
            if (phase == 35) phase = 0;
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        bit in_scan;
        in_scan = (phase >= 1 && phase <= 32);
        if (done) done_cnt++;
        chk("busy", 32'(busy), 32'(phase >= 1 && phase <= 34));
        chk("done", 32'(done), 32'(phase == 34));
        chk("mem_rd", 32'(mem_rd), 32'(in_scan));
        chk("mem_addr", 32'(mem_addr), in_scan ? 32'(32 - phase) : 32'd0);
        chk("h3", 32'(h3_out), 32'(exp_h[0]));
        chk("h2", 32'(h2_out), 32'(exp_h[1]));
        chk("h1", 32'(h1_out), 32'(exp_h[2]));
        chk("h0", 32'(h0_out), 32'(exp_h[3]));
        chk("count", 32'(count), 32'(exp_cnt));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] ln);
        start  = 1'b1;
        line_y = ln;
        tick();
        start  = 1'b0;
    endtask

    task automatic scan(input logic [8:0] ln);
        pulse_start(ln);
        repeat (36) tick();
    endtask

    task automatic clear_mem();
        for (int s = 0; s < 32; s++) begin
            ent[s]  = '0;
            ymem[s] = '0;
        end
    endtask

    initial begin
        int d0;
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            exp_h[i]  = '0;
            pend_h[i] = '0;
        end
        repeat (3) tick();
        chk("rst_h3", 32'(h3_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // ordering and tags
        ent[31] = 18'h00031; ymem[31] = 9'd100;
        ent[20] = 18'h00020; ymem[20] = 9'd100;
        ent[3]  = 18'h00003; ymem[3]  = 9'd100;
        d0 = done_cnt;
        scan(9'd105);
        chk("ord_h3", 32'(h3_out), 32'({5'd0, 18'h00031}));
        chk("ord_h2", 32'(h2_out), 32'({5'd11, 18'h00020}));
        chk("ord_h1", 32'(h1_out), 32'({5'd28, 18'h00003}));
        chk("ord_h0", 32'(h0_out), 32'd0);
        chk("ord_count", 32'(count), 32'd3);
        chk("ord_ovf", 32'(overflow), 32'd0);
        chk("ord_done_pulses", 32'(done_cnt - d0), 32'd1);

        // busy: second start at cycle 12 ignored, old list held until cycle 34
        clear_mem();
        ent[5] = 18'h3beef; ymem[5] = 9'd300;
        d0 = done_cnt;
        pulse_start(9'd305);
        repeat (11) tick();
        start = 1'b1; line_y = 9'd7;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("hold_h3", 32'(h3_out), 32'({5'd0, 18'h00031}));
        chk("hold_done", 32'(done), 32'd0);
        tick();
        chk("switch_done", 32'(done), 32'd1);
        chk("switch_h3", 32'(h3_out), 32'({5'd26, 18'h3beef}));
        chk("switch_count", 32'(count), 32'd1);
        repeat (3) tick();
        chk("busy_done_pulses", 32'(done_cnt - d0), 32'd1);

        // overflow
        for (int s = 0; s < 32; s++) begin
            ent[s]  = 18'(s + 1);
            ymem[s] = 9'd100;
        end
        scan(9'd100);
        chk("ovf_h3", 32'(h3_out), 32'({5'd0, 18'd32}));
        chk("ovf_h2", 32'(h2_out), 32'({5'd1, 18'd31}));
        chk("ovf_h1", 32'(h1_out), 32'({5'd2, 18'd30}));
        chk("ovf_h0", 32'(h0_out), 32'({5'd3, 18'd29}));
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // reset mid-scan
        d0 = done_cnt;
        pulse_start(9'd100);
        repeat (9) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_h3", 32'(h3_out), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd", 32'(mem_rd), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        scan(9'd100);
        chk("rescan_count", 32'(count), 32'd4);
        chk("rescan_done", 32'(done_cnt - d0), 32'd1);

        // height boundary
        clear_mem();
        ent[7] = 18'h01234; ymem[7] = 9'd200;
        scan(9'd215);
        chk("hb_in_count", 32'(count), 32'd1);
        chk("hb_in_h3", 32'(h3_out), 32'({5'd24, 18'h01234}));
        scan(9'd216);
        chk("hb_out_count", 32'(count), 32'd0);
        ent[7] = '0;
        scan(9'd210);
        chk("zero_entry_count", 32'(count), 32'd0);

        // wrap-around
        clear_mem();
        ent[9] = 18'h2aaaa; ymem[9] = 9'd510;
        scan(9'd5);
        chk("wrap_in_count", 32'(count), 32'd1);
        chk("wrap_in_h3", 32'(h3_out), 32'({5'd22, 18'h2aaaa}));
        scan(9'd14);
        chk("wrap_out_count", 32'(count), 32'd0);

        // randomized scans against the model
        for (int it = 0; it < 25; it++) begin
            logic [8:0] ln;
            ln = 9'($urandom_range(0, 511));
            for (int s = 0; s < 32; s++) begin
                ent[s] = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'($urandom);
                if ($urandom_range(0, 4) == 0) ymem[s] = 9'($urandom);
                else ymem[s] = 9'(int'(ln) - int'($urandom_range(0, 30)));
            end
            scan(ln);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Sequential per-scanline sprite evaluator for the visual processing unit. During horizontal blanking it scans the 32-entry sprite attribute memory one slot per cycle, highest slot first, and keeps the first four sprites visible on the upcoming line. The result goes into a double-buffered set of four 23-bit descriptors, `{tag[4:0], entry[17:0]}`, for the pixel pipeline. It replaces the single-cycle 32-input priority selector with a 34-cycle scan that reads one memory word at a time.

## Interface
- `SPRITE_H`, default 16: sprite height in lines, 1..256.
- `clk`  in  1: sole clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: single-cycle pulse at hblank start; ignored unless idle.
- `line_y`  in  9: line to evaluate, sampled with `start`.
- `mem_addr`  out  5: sprite attribute slot address.
- `mem_rd`  out  1: read strobe.
- `mem_entry`  in  18: sprite payload, registered 1 cycle after `mem_addr`/`mem_rd`; 0 means slot inactive.
- `mem_y`  in  9: sprite top line, same timing as `mem_entry`.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when outputs commit.
- `h3_out`, `h2_out`, `h1_out`, `h0_out`  out  23 each: committed descriptors; `h3` is the highest priority.
- `count`  out  3: visible sprites kept, 0..4.
- `overflow`  out  1: more than 4 sprites were visible on the line.

## Operation
- FSM states: IDLE, SCAN, DRAIN, COMMIT.
- **IDLE**
  - On `start`, capture `line_y` and go to SCAN.
  - Clear the working list, working count and the overflow flag.
- **SCAN** (32 cycles)
  - Set `mem_rd`=1.
  - `mem_addr` steps 31, 30, …, 0.
  - After slot 0 is issued, go to DRAIN.
- **DRAIN** (1 cycle)
  - `mem_rd`=0.
  - Evaluate the data for slot 0.
  - Go to COMMIT.
- **COMMIT** (1 cycle)
  - Copy the working list, count and overflow to the outputs.
  - Pulse `done` and go to IDLE.
- **Evaluation**, in the cycle after each issued address, for slot s:
  - Compute `diff = (line_y - mem_y) mod 512`, 9-bit wrap subtraction.
  - The slot is visible if `mem_entry != 0` and `diff < SPRITE_H`.
  - If visible and working count < 4: write `{5'(31-s), mem_entry}` to working position `count`, then increment the count.
  - If visible and working count == 4: set overflow.
- **List order**
  - Position 0 drives `h3_out`, 1 drives `h2_out`, 2 drives `h1_out`, 3 drives `h0_out`.
  - Unfilled positions are 23'd0.
- Tags are unique, 0..31; slot 31 gets tag 0.
- The scan always runs all 32 slots, even after 4 hits, so that overflow is exact.

## Timing
- `start` high in cycle 0 gives:
  - SCAN in cycles 1–32, with `mem_addr` = 32 − c.
  - DRAIN in cycle 33.
  - COMMIT in cycle 34: `done`=1, and outputs show new values from cycle 34 onward.
  - IDLE from cycle 35.
- Latency from `start` to `done` is 34 cycles.
- `busy`=1 in cycles 1–34.
- The earliest accepted restart is `start` in cycle 35.
- `start` while `busy`=1 is ignored, with no effect on the scan or `line_y`.
- Outputs (`h*_out`, `count`, `overflow`) are held stable between commits. Only COMMIT changes them: the working state is never visible.
- Reset values, all outputs:
  - `h*_out` = 0, `count` = 0, `overflow` = 0.
  - `busy` = 0, `done` = 0, `mem_rd` = 0, `mem_addr` = 0.
  - FSM in IDLE.
- Reset asserted mid-scan:
  - Immediate return to the reset state; no commit occurs.
  - The previous committed list is lost (outputs zero).
- Wrap-around:
  - `mem_y` near 511 with small `line_y` counts as visible through the mod-512 difference.
  - `line_y` < `mem_y` without wrap gives a large `diff`, so the slot is not visible.

## Test plan
- **Reset mid-scan:** reset at cycle 10 of a scan → all outputs 0 the same cycle, no `done`; a new `start` then runs a full 34-cycle scan.
- **Ordering and tags:** slots 31, 20, 3 active with `mem_y`=100, `line_y`=105, `SPRITE_H`=16 → at cycle 34:
  - `h3_out` = {0, e31}, `h2_out` = {11, e20}, `h1_out` = {28, e3}, `h0_out` = 0.
  - `count` = 3, `overflow` = 0, `done` one cycle.
- **Overflow:** all 32 slots active and visible → `h3..h0` tags 0, 1, 2, 3; `count` = 4, `overflow` = 1.
- **Height boundary:**
  - `mem_y` = 200, `line_y` = 215 → visible.
  - `line_y` = 216 → not visible.
  - Zero `mem_entry` with a matching `mem_y` → not visible.
- **Wrap:** `mem_y` = 510, `line_y` = 5 (diff 7) → visible; `line_y` = 14 (diff 16) → not visible.
- **Busy and double-buffering:** second `start` at cycle 12 → ignored, single `done` at cycle 34. Outputs hold the previous list until that cycle, then switch in one cycle.
